// File: rtl/apb_slave_pkg.sv
// Shared types for the APB register-bank completer: transfer FSM states, error causes
// and the fixed byte-strobe width.
package apb_slave_pkg;

  localparam int STRB_W = 4;

  typedef enum logic [1:0] {IDLE, SETUP, WAIT, RESP} apb_state_e;

  typedef enum logic [2:0] {ERR_NONE, ERR_SEL, ERR_ALIGN, ERR_RANGE, ERR_RO} apb_err_e;

  // Read-only identification word: {channel, word index} in the low half.
  function automatic logic [31:0] ro_word(input logic [7:0] ch, input logic [7:0] idx);
    return {16'h0000, ch, idx};
  endfunction

endpackage

// File: rtl/apb_slave_wait_ctrl.sv
// Transfer sequencer for the APB completer: walks IDLE/SETUP/WAIT/RESP and counts the
// programmed wait states; SETUP doubles as the first access cycle when waits are requested.
module apb_slave_wait_ctrl
  import apb_slave_pkg::*;
(
  input  logic       pclk,
  input  logic       preset,
  input  logic       psel_any,
  input  logic       penable,
  input  logic [3:0] cfg_wait,
  output logic       start,
  output logic       resp_next,
  output logic       access_fire,
  output logic       abort
);

  apb_state_e state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    start      = 1'b0;
    abort      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (psel_any && !penable) begin
          start    = 1'b1;
          cnt_next = cfg_wait;
          // Zero waits: the very first access cycle is already the response cycle.
          state_next = (cfg_wait == 4'd0) ? RESP : SETUP;
        end
      end
      SETUP, WAIT: begin
        if (!psel_any || !penable) begin
          abort      = 1'b1;
          cnt_next   = '0;
          state_next = IDLE;
        end else if (cnt_reg == 4'd1) begin
          cnt_next   = '0;
          state_next = RESP;
        end else begin
          cnt_next   = cnt_reg - 4'd1;
          state_next = WAIT;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign resp_next   = (state_next == RESP);
  assign access_fire = (state_reg == RESP);

endmodule

// File: rtl/apb_multi_slave_regbank.sv
// APB4 completer fronting NUM_CH register banks selected by one-hot psel, with byte
// strobes, programmable wait states and error reporting on decode/protocol faults.
module apb_multi_slave_regbank
  import apb_slave_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 16,
  parameter int APB_DATA_WIDTH = 32,
  parameter int NUM_CH         = 4,
  parameter int DEPTH          = 16,
  parameter int RO_WORDS       = 1
) (
  input  logic                      pclk,
  input  logic                      preset,
  input  logic [NUM_CH-1:0]         psel,
  input  logic                      penable,
  input  logic [APB_ADDR_WIDTH-1:0] paddr,
  input  logic                      pwrite,
  input  logic [APB_DATA_WIDTH-1:0] pwdata,
  input  logic [STRB_W-1:0]         pstrb,
  input  logic [3:0]                cfg_wait,
  output logic [APB_DATA_WIDTH-1:0] prdata,
  output logic                      pready,
  output logic                      pslverr
);

  localparam int IDX_W = APB_ADDR_WIDTH - 2;
  localparam int DEP_W = $clog2(DEPTH);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IDX_W-1:0] DEPTH_L = IDX_W'(DEPTH);
  localparam logic [IDX_W-1:0] RO_L    = IDX_W'(RO_WORDS);

  function automatic logic [CH_W-1:0] ch_enc(input logic [NUM_CH-1:0] sel);
    logic [CH_W-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel[i]) r = CH_W'(i);
    end
    return r;
  endfunction

  logic start, resp_next, access_fire, abort;

  apb_slave_wait_ctrl u_ctrl (
    .pclk        (pclk),
    .preset      (preset),
    .psel_any    (|psel),
    .penable     (penable),
    .cfg_wait    (cfg_wait),
    .start       (start),
    .resp_next   (resp_next),
    .access_fire (access_fire),
    .abort       (abort)
  );

  logic [NUM_CH-1:0]         psel_lat;
  logic [APB_ADDR_WIDTH-1:0] paddr_lat;
  logic                      pwrite_lat;
  logic [APB_DATA_WIDTH-1:0] pwdata_lat;
  logic [STRB_W-1:0]         pstrb_lat;
  logic [APB_DATA_WIDTH-1:0] prdata_reg;
  logic                      pslverr_reg;

  // The zero-wait path decides its response in the setup cycle, before anything is latched.
  logic [NUM_CH-1:0]         cur_sel;
  logic [APB_ADDR_WIDTH-1:0] cur_addr;
  logic                      cur_write;
  logic [IDX_W-1:0]          cur_idx;
  logic [CH_W-1:0]           cur_ch;
  apb_err_e                  err;
  logic [APB_DATA_WIDTH-1:0] rd_val;
  logic [APB_DATA_WIDTH-1:0] bank_rd [NUM_CH];

  assign cur_sel   = start ? psel   : psel_lat;
  assign cur_addr  = start ? paddr  : paddr_lat;
  assign cur_write = start ? pwrite : pwrite_lat;
  assign cur_idx   = cur_addr[APB_ADDR_WIDTH-1:2];
  assign cur_ch    = ch_enc(cur_sel);

  always_comb begin
    err = ERR_NONE;
    if (!$onehot(cur_sel))                err = ERR_SEL;
    else if (cur_addr[1:0] != 2'b00)      err = ERR_ALIGN;
    else if (cur_idx >= DEPTH_L)          err = ERR_RANGE;
    else if (cur_write && cur_idx < RO_L) err = ERR_RO;
  end

  always_comb begin
    rd_val = '0;
    if (err == ERR_NONE && !cur_write) begin
      if (cur_idx < RO_L) rd_val = APB_DATA_WIDTH'(ro_word(8'(cur_ch), cur_idx[7:0]));
      else                rd_val = bank_rd[cur_ch];
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      psel_lat    <= '0;
      paddr_lat   <= '0;
      pwrite_lat  <= 1'b0;
      pwdata_lat  <= '0;
      pstrb_lat   <= '0;
      prdata_reg  <= '0;
      pslverr_reg <= 1'b0;
    end else begin
      if (start) begin
        psel_lat   <= psel;
        paddr_lat  <= paddr;
        pwrite_lat <= pwrite;
        pwdata_lat <= pwdata;
        pstrb_lat  <= pstrb;
      end else if (abort) begin
        pwrite_lat <= 1'b0;
      end
      prdata_reg  <= resp_next ? rd_val : '0;
      pslverr_reg <= resp_next && (err != ERR_NONE);
    end
  end

  // A faulted write is already flagged in pslverr_reg during RESP, so it gates the commit.
  logic            commit;
  logic [CH_W-1:0] wr_ch;
  logic [DEP_W-1:0] wr_idx;

  assign commit = access_fire && pwrite_lat && !pslverr_reg;
  assign wr_ch  = ch_enc(psel_lat);
  assign wr_idx = paddr_lat[DEP_W+1:2];

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_bank
      logic [APB_DATA_WIDTH-1:0] bank [DEPTH];

      always_ff @(posedge pclk) begin
        if (preset) begin
          for (int w = 0; w < DEPTH; w++) bank[w] <= '0;
        end else if (commit && wr_ch == CH_W'(gi)) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (pstrb_lat[b]) bank[wr_idx][8*b +: 8] <= pwdata_lat[8*b +: 8];
          end
        end
      end

      assign bank_rd[gi] = bank[cur_idx[DEP_W-1:0]];
    end
  endgenerate

  assign prdata  = prdata_reg;
  assign pready  = access_fire;
  assign pslverr = pslverr_reg;

endmodule

// File: tb/tb_apb_multi_slave_regbank.sv
// Directed bench for the APB register bank: the driver queues expected responses, a
// negedge monitor pops and compares them whenever pready is seen.
module tb_apb_multi_slave_regbank;

  logic        pclk = 1'b0;
  logic        preset;
  logic [3:0]  psel;
  logic        penable;
  logic [15:0] paddr;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [3:0]  cfg_wait;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  apb_multi_slave_regbank #(
    .APB_ADDR_WIDTH (16),
    .APB_DATA_WIDTH (32),
    .NUM_CH         (4),
    .DEPTH          (16),
    .RO_WORDS       (1)
  ) dut (
    .pclk     (pclk),
    .preset   (preset),
    .psel     (psel),
    .penable  (penable),
    .paddr    (paddr),
    .pwrite   (pwrite),
    .pwdata   (pwdata),
    .pstrb    (pstrb),
    .cfg_wait (cfg_wait),
    .prdata   (prdata),
    .pready   (pready),
    .pslverr  (pslverr)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    int          id;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   txn_id = 0;

  always @(negedge pclk) begin
    if (pready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pready: prdata=%h pslverr=%b, required no response", prdata, pslverr);
      end else begin
        mon_e = exp_q.pop_front();
        checks += 2;
        if (prdata !== mon_e.data) begin
          errors++;
          $display("FAIL txn%0d_prdata: got %h, required %h", mon_e.id, prdata, mon_e.data);
        end
        if (pslverr !== mon_e.err) begin
          errors++;
          $display("FAIL txn%0d_pslverr: got %b, required %b", mon_e.id, pslverr, mon_e.err);
        end
        $display("txn %0d: prdata=%h pslverr=%b", mon_e.id, prdata, pslverr);
      end
    end
  end

  task automatic xfer(input logic [3:0] sel, input logic [15:0] addr, input logic wr,
                      input logic [31:0] wd, input logic [3:0] st, input logic [3:0] w,
                      input logic [3:0] w_mid, input logic [31:0] ed, input logic ee);
    int lat;
    @(posedge pclk); #1;
    psel = sel; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = wd; pstrb = st; cfg_wait = w;
    exp_q.push_back('{txn_id, ed, ee});
    txn_id++;
    @(posedge pclk); #1;
    penable  = 1'b1;
    cfg_wait = w_mid;
    lat = 1;
    @(negedge pclk);
    while (!pready && lat < 40) begin
      lat++;
      @(negedge pclk);
    end
    checks++;
    if (lat != int'(w) + 1) begin
      errors++;
      $display("FAIL txn%0d_latency: pready in access cycle %0d, required %0d", txn_id - 1, lat, int'(w) + 1);
    end
  endtask

  task automatic idle();
    @(posedge pclk); #1;
    psel = '0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic wr(input logic [3:0] sel, input logic [15:0] addr, input logic [31:0] d,
                    input logic [3:0] st, input logic ee);
    xfer(sel, addr, 1'b1, d, st, 4'd0, 4'd0, 32'h0, ee);
    idle();
  endtask

  task automatic rd(input logic [3:0] sel, input logic [15:0] addr, input logic [31:0] ed,
                    input logic ee);
    xfer(sel, addr, 1'b0, 32'h0, 4'hF, 4'd0, 4'd0, ed, ee);
    idle();
  endtask

  task automatic check_idle_outputs(input string tag);
    @(negedge pclk);
    checks += 3;
    if (pready !== 1'b0)   begin errors++; $display("FAIL %s_pready: got %b, required 0", tag, pready); end
    if (prdata !== 32'h0)  begin errors++; $display("FAIL %s_prdata: got %h, required 0", tag, prdata); end
    if (pslverr !== 1'b0)  begin errors++; $display("FAIL %s_pslverr: got %b, required 0", tag, pslverr); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    preset = 1'b1; psel = '0; penable = 1'b0; paddr = '0; pwrite = 1'b0;
    pwdata = '0; pstrb = '0; cfg_wait = '0;
    repeat (3) @(posedge pclk);
    check_idle_outputs("reset");
    @(posedge pclk); #1;
    preset = 1'b0;

    // RO identification word and basic strobed writes
    rd(4'b0010, 16'h0000, 32'h0000_0100, 1'b0);
    wr(4'b0001, 16'h0008, 32'hDEAD_BEEF, 4'hF, 1'b0);
    wr(4'b0001, 16'h0008, 32'h0000_1234, 4'h3, 1'b0);
    rd(4'b0001, 16'h0008, 32'hDEAD_1234, 1'b0);

    // Wait states; cfg_wait changed during the access must not matter
    xfer(4'b0001, 16'h0008, 1'b0, 32'h0, 4'hF, 4'd3, 4'd0, 32'hDEAD_1234, 1'b0);
    idle();
    xfer(4'b1000, 16'h0000, 1'b0, 32'h0, 4'hF, 4'd1, 4'd7, 32'h0000_0300, 1'b0);
    idle();

    // Fault cases
    rd(4'b0001, 16'h0041, 32'h0, 1'b1);
    wr(4'b0001, 16'h0009, 32'hFFFF_FFFF, 4'hF, 1'b1);
    rd(4'b0001, 16'h0040, 32'h0, 1'b1);
    wr(4'b0011, 16'h0008, 32'h0000_0000, 4'hF, 1'b1);
    rd(4'b0010, 16'h0008, 32'h0, 1'b0);
    wr(4'b0100, 16'h0000, 32'h0000_FFFF, 4'hF, 1'b1);
    rd(4'b0100, 16'h0000, 32'h0000_0200, 1'b0);
    wr(4'b0001, 16'h0008, 32'h0000_0000, 4'h0, 1'b0);
    rd(4'b0001, 16'h0008, 32'hDEAD_1234, 1'b0);

    // Abort: psel dropped during a 5-wait write
    xfer(4'b0010, 16'h000C, 1'b1, 32'hA5A5_A5A5, 4'hF, 4'd2, 4'd2, 32'h0, 1'b0);
    idle();
    @(posedge pclk); #1;
    psel = 4'b0010; penable = 1'b0; paddr = 16'h000C; pwrite = 1'b1;
    pwdata = 32'h0000_0055; pstrb = 4'hF; cfg_wait = 4'd5;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    psel = '0; penable = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge pclk);
      if (pready) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_no_pready: saw %0d pready cycles, required 0", seen);
    end
    rd(4'b0010, 16'h000C, 32'hA5A5_A5A5, 1'b0);

    // Back-to-back ch2 then ch3 writes, reset asserted while the second waits
    xfer(4'b0100, 16'h0008, 1'b1, 32'h1111_2222, 4'hF, 4'd0, 4'd0, 32'h0, 1'b0);
    @(posedge pclk); #1;
    psel = 4'b1000; penable = 1'b0; paddr = 16'h0014; pwrite = 1'b1;
    pwdata = 32'h3333_4444; pstrb = 4'hF; cfg_wait = 4'd3;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    @(posedge pclk); #1;
    preset = 1'b1; psel = '0; penable = 1'b0; pwrite = 1'b0;
    check_idle_outputs("midwait_reset");
    @(posedge pclk); #1;
    preset = 1'b0;
    rd(4'b0100, 16'h0008, 32'h0, 1'b0);
    rd(4'b1000, 16'h0014, 32'h0, 1'b0);
    xfer(4'b1000, 16'h0000, 1'b0, 32'h0, 4'hF, 4'd2, 4'd2, 32'h0000_0300, 1'b0);
    idle();

    repeat (3) @(posedge pclk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_responses: %0d outstanding, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
